// File: rtl/de1_sram_arb_pkg.sv
// Shared definitions for the DE1 SRAM arbiter and its PHY sequencer.
// Round-robin arbitration is selected by defining CONFIG_SRAM_ARB_ROUND_ROBIN_EN.
package de1_sram_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAcc,
      StAck
   } sram_state_e;

   localparam int unsigned DEF_ACCESS_CYCLES = 2;
   localparam int unsigned DEF_ADDR_WIDTH    = 18;
   localparam int unsigned CNT_WIDTH         = 4;

endpackage

// File: rtl/de1_sram_phy.sv
// SRAM access sequencer: SETUP/ACC/ACK timing, registered SRAM pins and the
// dq tristate driver for one access at a time.
module de1_sram_phy
   import de1_sram_arb_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
   parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  start_we,
   input  logic [1:0]            start_sel,
   input  logic [ADDR_WIDTH-1:0] start_adr,
   input  logic [15:0]           start_dat,
   output sram_state_e           state,
   output logic                  ack,
   output logic                  rd_capture,
   output logic [15:0]           rd_data,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   inout  wire  [15:0]           sram_dq,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic                  sram_ub_n,
   output logic                  sram_lb_n
);

   if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
      $error("ACCESS_CYCLES must lie in 1..15");
   end

   sram_state_e           state_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  we_q;
   logic                  dq_oe_q;
   logic                  ack_q;
   logic [15:0]           wdat_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;

   // Pins are computed from the next state so they are valid for the whole state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         dq_oe_q <= 1'b0;
         ack_q   <= 1'b0;
         wdat_q  <= '0;
         addr_q  <= '0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
      end else begin
         ack_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StSetup;
                  addr_q  <= start_adr;
                  we_q    <= start_we;
                  wdat_q  <= start_dat;
                  ce_n_q  <= 1'b0;
                  oe_n_q  <= start_we;
                  dq_oe_q <= start_we;
                  ub_n_q  <= ~start_sel[1];
                  lb_n_q  <= ~start_sel[0];
               end
            end
            StSetup: begin
               state_q <= StAcc;
               cnt_q   <= CNT_WIDTH'(ACCESS_CYCLES - 1);
               we_n_q  <= ~we_q;
            end
            StAcc: begin
               if (cnt_q == '0) begin
                  state_q <= StAck;
                  oe_n_q  <= 1'b1;
                  we_n_q  <= 1'b1;
                  ack_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_WIDTH'(1);
               end
            end
            StAck: begin
               // Releasing ce_n and dq here forces one idle turnaround clock.
               state_q <= StIdle;
               ce_n_q  <= 1'b1;
               dq_oe_q <= 1'b0;
               ub_n_q  <= 1'b1;
               lb_n_q  <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign state      = state_q;
   assign ack        = ack_q;
   assign rd_capture = (state_q == StAcc) && (cnt_q == '0) && !we_q;
   assign rd_data    = sram_dq;
   assign sram_dq    = dq_oe_q ? wdat_q : {16{1'bz}};
   assign sram_addr  = addr_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;
   assign sram_ub_n  = ub_n_q;
   assign sram_lb_n  = lb_n_q;

endmodule

// File: rtl/de1_sram_arb.sv
// Two-master Wishbone arbiter in front of the DE1 256Kx16 asynchronous SRAM.
// Fixed m0 priority by default; CONFIG_SRAM_ARB_ROUND_ROBIN_EN selects round-robin.
module de1_sram_arb
   import de1_sram_arb_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
   parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [1:0]            m0_sel_i,
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [15:0]           m0_dat_i,
   output logic [15:0]           m0_dat_o,
   output logic                  m0_ack_o,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [1:0]            m1_sel_i,
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [15:0]           m1_dat_i,
   output logic [15:0]           m1_dat_o,
   output logic                  m1_ack_o,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   inout  wire  [15:0]           sram_dq,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic                  sram_ub_n,
   output logic                  sram_lb_n,
   output logic                  busy_o
);

   logic                  m0_req, m1_req;
   logic                  start;
   logic                  grant_d, grant_q;
   logic                  st_we;
   logic [1:0]            st_sel;
   logic [ADDR_WIDTH-1:0] st_adr;
   logic [15:0]           st_dat;
   sram_state_e           state;
   logic                  phy_ack;
   logic                  rd_capture;
   logic [15:0]           rd_data;
   logic [15:0]           m0_dat_q, m1_dat_q;

   assign m0_req = m0_cyc_i & m0_stb_i;
   assign m1_req = m1_cyc_i & m1_stb_i;
   assign start  = (state == StIdle) & (m0_req | m1_req);

`ifdef CONFIG_SRAM_ARB_ROUND_ROBIN_EN
   logic rr_ptr_q;  // master favoured on the next simultaneous request

   assign grant_d = (m0_req & m1_req) ? rr_ptr_q : ~m0_req;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rr_ptr_q <= 1'b0;
      end else if (start) begin
         rr_ptr_q <= ~grant_d;
      end
   end
`else
   assign grant_d = ~m0_req & m1_req;
`endif

   always_comb begin
      if (grant_d) begin
         st_we  = m1_we_i;
         st_sel = m1_sel_i;
         st_adr = m1_adr_i;
         st_dat = m1_dat_i;
      end else begin
         st_we  = m0_we_i;
         st_sel = m0_sel_i;
         st_adr = m0_adr_i;
         st_dat = m0_dat_i;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         grant_q  <= 1'b0;
         m0_dat_q <= '0;
         m1_dat_q <= '0;
      end else begin
         if (start) begin
            grant_q <= grant_d;
         end
         if (rd_capture) begin
            if (grant_q) begin
               m1_dat_q <= rd_data;
            end else begin
               m0_dat_q <= rd_data;
            end
         end
      end
   end

   de1_sram_phy #(
      .ACCESS_CYCLES (ACCESS_CYCLES),
      .ADDR_WIDTH    (ADDR_WIDTH)
   ) u_phy (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .start      (start),
      .start_we   (st_we),
      .start_sel  (st_sel),
      .start_adr  (st_adr),
      .start_dat  (st_dat),
      .state      (state),
      .ack        (phy_ack),
      .rd_capture (rd_capture),
      .rd_data    (rd_data),
      .sram_addr  (sram_addr),
      .sram_dq    (sram_dq),
      .sram_ce_n  (sram_ce_n),
      .sram_oe_n  (sram_oe_n),
      .sram_we_n  (sram_we_n),
      .sram_ub_n  (sram_ub_n),
      .sram_lb_n  (sram_lb_n)
   );

   assign m0_ack_o = phy_ack & ~grant_q;
   assign m1_ack_o = phy_ack & grant_q;
   assign m0_dat_o = m0_dat_q;
   assign m1_dat_o = m1_dat_q;
   assign busy_o   = (state != StIdle);

endmodule

// File: tb/tb_de1_sram_arb.sv
// Bench for de1_sram_arb: vector table plus hand-written corner sequences,
// with an SRAM model and an ack scoreboard.
module tb_de1_sram_arb;
   localparam int AC      = 2;
   localparam int AW      = 18;
   localparam int TIMEOUT = 40;
`ifdef CONFIG_SRAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic m0_cyc, m0_stb, m0_we, m0_ack, m1_cyc, m1_stb, m1_we, m1_ack;
   logic [1:0] m0_sel, m1_sel;
   logic [AW-1:0] m0_adr, m1_adr, sram_addr;
   logic [15:0] m0_wd, m0_rd, m1_wd, m1_rd;
   wire  [15:0] sram_dq;
   logic ce_n, oe_n, we_n, ub_n, lb_n, busy;

   always #5 clk = ~clk;

   de1_sram_arb #(.ACCESS_CYCLES(AC), .ADDR_WIDTH(AW)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_wd), .m0_dat_o(m0_rd), .m0_ack_o(m0_ack),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_wd), .m1_dat_o(m1_rd), .m1_ack_o(m1_ack),
      .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
      .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n), .busy_o(busy)
   );

   // SRAM model; probe_en pulls dq to 0 so a stray DUT driver becomes visible.
   logic [15:0] mem [0:(1<<AW)-1];
   logic bd_we, probe_en, model_rd, tb_dq_en;
   logic [AW-1:0] bd_adr;
   logic [15:0] bd_dat, tb_dq_val;

   always @(posedge clk) begin
      if (bd_we) mem[bd_adr] <= bd_dat;
      else if (!ce_n && !we_n) begin
         if (!lb_n) mem[sram_addr][7:0] <= sram_dq[7:0];
         if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
      end
   end

   always_comb begin
      model_rd  = !ce_n && !oe_n && we_n;
      tb_dq_en  = model_rd | probe_en;
      tb_dq_val = model_rd ? mem[sram_addr] : 16'h0000;
   end
   assign sram_dq = tb_dq_en ? tb_dq_val : 16'hzzzz;

   typedef struct packed {
      bit mst; bit we; logic [1:0] sel; logic [AW-1:0] adr; logic [15:0] wd; logic [15:0] rd;
   } vec_t;
   typedef struct packed { bit mst; bit we; logic [15:0] dat; } exp_t;

   vec_t vecs [8];
   exp_t exp_q [$];
   logic [15:0] exp_dat [2];
   int n_cmp = 0, n_err = 0;
   int oe_lo, we_lo, ce_lo, dq_hit;
   bit last_mst;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input bit mst, input bit we, input logic [15:0] dat);
      exp_t e;
      e.mst = mst; e.we = we; e.dat = dat;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit mst, input bit req, input bit we, input logic [1:0] sel,
                        input logic [AW-1:0] adr, input logic [15:0] wd);
      if (mst) begin
         m1_cyc = req; m1_stb = req; m1_we = we; m1_sel = sel; m1_adr = adr; m1_wd = wd;
      end else begin
         m0_cyc = req; m0_stb = req; m0_we = we; m0_sel = sel; m0_adr = adr; m0_wd = wd;
      end
   endtask

   task automatic backdoor(input logic [AW-1:0] adr, input logic [15:0] dat);
      bd_adr = adr; bd_dat = dat; bd_we = 1'b1;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic clr_counts();
      oe_lo = 0; we_lo = 0; ce_lo = 0; dq_hit = 0;
   endtask

   // Counts cycles after the request edge until an ack or stop_at is reached.
   task automatic wait_ack(input bit we, input logic [15:0] wd, input logic [1:0] sel,
                           input int stop_at, inout int n, output bit got);
      logic [1:0] be, nsel;
      got = 1'b0;
      nsel = ~sel;
      while (!got && n < stop_at) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            be = {ub_n, lb_n};
            check("setup_byte_en", be, nsel);
         end
         if (!oe_n) oe_lo++;
         if (!we_n) we_lo++;
         if (!ce_n) ce_lo++;
         if (we && sram_dq === wd) dq_hit++;
         if (m0_ack | m1_ack) got = 1'b1;
      end
   endtask

   task automatic score(input bit got, input int n, input int lat);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard: got an ack, expected none pending");
         return;
      end
      e = exp_q.pop_front();
      check("ack_seen", got, 1);
      if (!got) return;
      if (lat > 0) check("ack_latency", n, lat);
      check("ack_onehot", m0_ack & m1_ack, 0);
      check("ack_master", m1_ack, e.mst);
      if (!e.we) begin
         exp_dat[e.mst] = e.dat;
         check("read_data", e.mst ? m1_rd : m0_rd, e.dat);
      end
      check("m0_dat_hold", m0_rd, exp_dat[0]);
      check("m1_dat_hold", m1_rd, exp_dat[1]);
   endtask

   task automatic idle_check();
      probe_en = 1'b1;
      @(negedge clk);
      check("idle_ce_n", ce_n, 1);
      check("idle_dq_released", sram_dq, 0);
      check("idle_busy", busy, 0);
      check("idle_no_ack", m0_ack | m1_ack, 0);
      probe_en = 1'b0;
   endtask

   task automatic reset_check(input string pfx);
      logic [4:0] pins;
      probe_en = 1'b1;
      @(negedge clk);
      pins = {ce_n, oe_n, we_n, ub_n, lb_n};
      check({pfx, "_pins"}, pins, 5'h1f);
      check({pfx, "_addr"}, sram_addr, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_acks"}, {m0_ack, m1_ack}, 0);
      check({pfx, "_dat"}, {m0_rd, m1_rd}, 0);
      check({pfx, "_dq"}, sram_dq, 0);
      probe_en = 1'b0;
   endtask

   task automatic access(input vec_t v);
      int n;
      bit got;
      push_exp(v.mst, v.we, v.rd);
      drive(v.mst, 1'b1, v.we, v.sel, v.adr, v.wd);
      clr_counts();
      n = 0;
      @(posedge clk);
      wait_ack(v.we, v.wd, v.sel, TIMEOUT, n, got);
      score(got, n, AC + 2);
      check("ce_low_cycles", ce_lo, AC + 2);
      check("oe_low_cycles", oe_lo, v.we ? 0 : AC + 1);
      check("we_low_cycles", we_lo, v.we ? AC : 0);
      if (v.we) check("dq_drive_cycles", dq_hit, AC + 2);
      @(posedge clk); #1;
      drive(v.mst, 1'b0, 1'b0, 2'b00, '0, '0);
      last_mst = v.mst;
      idle_check();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      int n, t, prev, k, cnt0, cnt1;
      bit got, first;
      vec_t v;

      vecs[0] = '{mst:1'b0, we:1'b0, sel:2'b11, adr:18'h00100, wd:16'h0000, rd:16'h1234};
      vecs[1] = '{mst:1'b1, we:1'b1, sel:2'b10, adr:18'h3FFFF, wd:16'hA55A, rd:16'h0000};
      vecs[2] = '{mst:1'b0, we:1'b0, sel:2'b11, adr:18'h3FFFF, wd:16'h0000, rd:16'hA511};
      vecs[3] = '{mst:1'b1, we:1'b1, sel:2'b11, adr:18'h00200, wd:16'hBEEF, rd:16'h0000};
      vecs[4] = '{mst:1'b0, we:1'b1, sel:2'b00, adr:18'h00200, wd:16'h0F0F, rd:16'h0000};
      vecs[5] = '{mst:1'b1, we:1'b0, sel:2'b11, adr:18'h00200, wd:16'h0000, rd:16'hBEEF};
      vecs[6] = '{mst:1'b0, we:1'b1, sel:2'b01, adr:18'h00300, wd:16'h12CD, rd:16'h0000};
      vecs[7] = '{mst:1'b1, we:1'b0, sel:2'b11, adr:18'h00300, wd:16'h0000, rd:16'hFFCD};

      rst = 1'b1; probe_en = 1'b0; bd_we = 1'b0; bd_adr = '0; bd_dat = '0;
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
      drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
      exp_dat[0] = '0; exp_dat[1] = '0; last_mst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_check("reset");
      backdoor(18'h00100, 16'h1234);
      backdoor(18'h3FFFF, 16'h1111);
      backdoor(18'h00200, 16'h0000);
      backdoor(18'h00300, 16'hFFFF);
      backdoor(18'h00400, 16'h1357);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) access(vecs[i]);

      // Both masters request together and hold until each has four acks.
      first = RR ? ~last_mst : 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (RR) push_exp(first ^ i[0], 1'b0, 16'h1234);
         else push_exp(i >= 4, 1'b0, 16'h1234);
      end
      drive(1'b0, 1'b1, 1'b0, 2'b11, 18'h00100, '0);
      drive(1'b1, 1'b1, 1'b0, 2'b11, 18'h00100, '0);
      t = 0; prev = 0; k = 0; cnt0 = 0; cnt1 = 0;
      while (k < 8 && t < 8 * TIMEOUT) begin
         @(negedge clk);
         t++;
         if (m0_ack | m1_ack) begin
            if (m1_ack) cnt1++; else cnt0++;
            score(1'b1, 0, 0);
            if (k > 0) check("b2b_period", t - prev, AC + 3);
            prev = t;
            k++;
            @(posedge clk); #1;
            if (cnt0 == 4) drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
            if (cnt1 == 4) drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
         end
      end
      check("simul_acks", k, 8);
      while (exp_q.size() > 0) void'(exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
      drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
      idle_check();

      // m0 abandons the cycle during ACC; the access still completes and acks.
      push_exp(1'b0, 1'b0, 16'hFFCD);
      drive(1'b0, 1'b1, 1'b0, 2'b11, 18'h00300, '0);
      clr_counts(); n = 0;
      @(posedge clk);
      wait_ack(1'b0, '0, 2'b11, 2, n, got);
      check("drop_busy_in_acc", busy, 1);
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
      wait_ack(1'b0, '0, 2'b11, TIMEOUT, n, got);
      score(got, n, AC + 2);
      check("drop_oe_low_cycles", oe_lo, AC + 1);
      @(posedge clk); #1;
      idle_check();

      // Reset in the middle of an m1 write; the held request is re-run afterwards.
      drive(1'b1, 1'b1, 1'b1, 2'b11, 18'h00400, 16'h7777);
      clr_counts(); n = 0;
      @(posedge clk);
      wait_ack(1'b1, 16'h7777, 2'b11, 2, n, got);
      check("rst_pre_we_low", we_n, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      exp_dat[0] = '0; exp_dat[1] = '0;
      reset_check("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      push_exp(1'b1, 1'b1, '0);
      clr_counts(); n = 0;
      @(posedge clk);
      wait_ack(1'b1, 16'h7777, 2'b11, TIMEOUT, n, got);
      score(got, n, AC + 2);
      check("rst_retry_we_low", we_lo, AC);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
      idle_check();
      v = '{mst:1'b0, we:1'b0, sel:2'b11, adr:18'h00400, wd:16'h0000, rd:16'h7777};
      access(v);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/de1_sram_arb.md
Name: de1_sram_arb

Overview:
- Two-master Wishbone arbiter and sequencer for the DE1 on-board 256Kx16 asynchronous SRAM.
- Port m0 serves the CPU bus; port m1 serves a secondary requester (DMA, video or debug loader).
- Generates SRAM ce/oe/we/ub/lb/address and tristate data timing with a programmable access width.
- Sits in the de1 top level between the bus fabric and the de1_sram_* pins.

Parameters:
- ACCESS_CYCLES, 2: number of clocks the SRAM strobe (oe_n or we_n) is held active; legal range 1..15.
- ADDR_WIDTH, 18: SRAM word-address width.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  synchronous active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone cycle, strobe, write enable
- m0_sel_i  in  2  byte lanes: [0] = low byte, [1] = high byte
- m0_adr_i  in  ADDR_WIDTH  word address
- m0_dat_i  in  16  write data
- m0_dat_o  out  16  read data
- m0_ack_o  out  1  acknowledge
- m1_*  (same set as m0)  master 1
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_dq  inout  16  SRAM data bus
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM controls, all active low
- busy_o  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset values: all *_n outputs 1; sram_addr 0; dq driver off (high-Z); m0/m1 ack_o 0; dat_o 0; busy_o 0; FSM in IDLE; grant register 0; round-robin pointer selects m0.
- Request condition: mX_req = mX_cyc_i & mX_stb_i.
- FSM states are IDLE, SETUP, ACC, ACK.
- IDLE:
  - Any request: latch grant, address, we, sel and write data; go to SETUP.
  - No request: stay in IDLE.
- SETUP (1 clk):
  - ce_n = 0; ub_n/lb_n = ~sel.
  - Read: oe_n = 0. Write: dq driven, we_n held at 1.
- ACC (ACCESS_CYCLES clks):
  - Read: oe_n held at 0.
  - Write: we_n = 0, dq driven.
  - Counter loads ACCESS_CYCLES-1 on entry and decrements.
  - Read data is sampled from sram_dq on the last ACC edge into the granted master's dat_o.
- ACK (1 clk):
  - we_n and oe_n return to 1; ce_n stays 0.
  - Write data is still driven, giving hold time.
  - Granted master's ack_o = 1, registered.
  - Next state is IDLE.
- In IDLE: ce_n = 1 and the dq driver is off. This gives one mandatory bus-turnaround clock between accesses.
- Latency:
  - A request sampled at edge 0 produces ack_o high during cycle ACCESS_CYCLES+2.
  - Back-to-back throughput is one access per ACCESS_CYCLES+3 clocks.
- Arbitration in IDLE only:
  - Single requester: that master wins.
  - Simultaneous requests: resolved by the priority rule (see Optional Feature).
  - A grant is never changed mid-access.
- Master drops cyc/stb mid-access: the access completes on the SRAM and the ack is still issued for one cycle.
- The non-granted master's ack_o stays 0 and its dat_o holds its last value.
- Byte write with sel = 2'b00: the access is still sequenced and acked; ub_n = lb_n = 1, so memory is not modified.
- Address is not incremented; no bursts. A block/incrementing cycle type is treated as a single access.
- wb_rst_i asserted in any state:
  - Next edge returns every output to its reset value and drops the dq driver.
  - Any in-flight access is abandoned with no ack.
  - After reset deasserts, pending requests are re-arbitrated from IDLE.

Optional Feature:
- Macro: CONFIG_SRAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin on simultaneous requests. The master not granted last wins, and the pointer updates on every grant.
- Undefined: fixed priority, m0 always wins; m1 is served only when m0 is not requesting in IDLE.

Decomposition:
- Shared package/include (config.v style): FSM state encoding constants, default ACCESS_CYCLES, and the macro above.
- One natural sub-module, de1_sram_phy: owns the SETUP/ACC/ACK timing counter, SRAM pin registers and the dq tristate.
- The top arbiter keeps request muxing, grant and pointer logic, and ack/dat_o routing.

Test Plan:
- m0 read at adr 18'h00100, ACCESS_CYCLES=2, SRAM model returns 16'h1234:
  - oe_n low 3 clks, we_n never low.
  - m0_ack_o high exactly at cycle 4, m0_dat_o = 16'h1234, m1_ack_o stays 0.
- m1 write to 18'h3FFFF, data 16'hA55A, sel = 2'b10:
  - ub_n = 0, lb_n = 1, we_n low 2 clks in ACC.
  - dq driven from SETUP through ACK; readback gives high byte A5 with the low byte unchanged.
- m0 and m1 request on the same edge, held for 4 accesses:
  - Without the macro, m0 served all 4 before m1.
  - With the macro, grants alternate m0, m1, m0, m1.
- m0 drops stb during ACC: the access completes and ack pulses 1 clk; the next idle cycle shows ce_n = 1 and dq high-Z.
- wb_rst_i asserted during an ACC write: next edge all *_n = 1, dq high-Z, no ack; after release the pending m1 request is granted from IDLE.
- sel = 2'b00 write: the access is acked at cycle 4 with ub_n = lb_n = 1, and memory contents are unchanged.
